// File: rtl/reg_sched_pkg.sv
// reg_sched_pkg
// Shared types and defaults for the register access scheduler.
//   state_t      : scheduler FSM states (IDLE, ACCESS, DONE)
//   DEF_*        : default requester count, register count, address and data widths
//   REG_WRITE_N  : level of a per-register write strobe when writing
//   idx_width()  : width needed to hold a requester index (at least 1 bit)
package reg_sched_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_NREG = 4;
  localparam int DEF_AW   = 2;
  localparam int DEF_W    = 16;

  localparam logic REG_WRITE_N = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_access_sched_rr_pick.sv
// rr_pick
// Combinational winner select for the register access scheduler.
// Configuration macro: REG_SCHED_FIXED_PRIO_EN
//   undefined : round-robin, first requester at or after ptr wins (with wrap)
//   defined   : fixed priority, lowest index wins; no ptr port
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IW    round-robin start position (round-robin build only)
//   idx   out IW    index of the winning requester
//   valid out 1     at least one request is pending
module rr_pick
  import reg_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef REG_SCHED_FIXED_PRIO_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [IW-1:0]   idx,
  output logic            valid
);

`ifdef REG_SCHED_FIXED_PRIO_EN

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

`else

  logic [NREQ-1:0] rot;
  int              off;

  // Rotate the request vector so position 0 is the requester at ptr, find the
  // closest set bit, then map the offset back to an absolute index.
  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    valid = 1'b0;
    off   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        off   = j;
      end
    end
    idx = IW'((int'(ptr) + off) % NREQ);
  end

`endif

endmodule

// File: rtl/reg_access_sched.sv
// reg_access_sched
// Shares a bank of registers between NREQ requesters. Each transaction takes
// IDLE -> ACCESS -> DONE; every output is driven straight from a flop.
// Configuration macro: REG_SCHED_FIXED_PRIO_EN (fixed priority instead of
// round-robin; the pointer register is then absent).
// Ports:
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous reset, active high
//   req        in   NREQ     per-requester request, held until done
//   req_we     in   NREQ     1 = write, 0 = read
//   req_addr   in   NREQ*AW  register address, slice i for requester i
//   req_wdata  in   NREQ*W   write data, slice i for requester i
//   gnt        out  NREQ     one-hot grant during the access cycle
//   done       out  NREQ     one-cycle completion pulse
//   rdata      out  W        last read result
//   busy       out  1        high whenever not IDLE
//   reg_rw_n   out  NREG     per-register write strobe, low = write
//   reg_ea     out  NREG     per-register read enable onto reg_qa
//   reg_d      out  W        write data to the bank
//   reg_qa     in   W        shared read bus from the bank
module reg_access_sched
  import reg_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int W    = DEF_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      rdata,
  output logic              busy,
  output logic [NREG-1:0]   reg_rw_n,
  output logic [NREG-1:0]   reg_ea,
  output logic [W-1:0]      reg_d,
  input  logic [W-1:0]      reg_qa
);

  localparam int IW = idx_width(NREQ);

  state_t          state;
  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;

  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [W-1:0]    win_wdata;
  logic [NREG-1:0] hot;

`ifndef REG_SCHED_FIXED_PRIO_EN
  logic [IW-1:0]   ptr;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
`ifndef REG_SCHED_FIXED_PRIO_EN
    .ptr   (ptr),
`endif
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_we    = req_we[win_idx];
  assign win_addr  = req_addr[win_idx*AW +: AW];
  assign win_wdata = req_wdata[win_idx*W +: W];

  // One-hot register select for the winner; an address at or beyond NREG
  // matches no bit, so no strobe fires for it.
  always_comb begin
    hot = '0;
    for (int r = 0; r < NREG; r++) begin
      hot[r] = (int'(win_addr) == r);
    end
  end

  // Strobes and grant are loaded on the edge that enters ACCESS so they are
  // valid for exactly that cycle; the edge leaving ACCESS clears them and
  // raises done, so the bank write and the read capture share that edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rdata    <= '0;
      reg_d    <= '0;
      reg_rw_n <= {NREG{~REG_WRITE_N}};
      reg_ea   <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
`ifndef REG_SCHED_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            idx_q  <= win_idx;
            we_q   <= win_we;
            addr_q <= win_addr;
            gnt    <= NREQ'(1) << win_idx;
            busy   <= 1'b1;
            if (win_we) begin
              for (int r = 0; r < NREG; r++) begin
                reg_rw_n[r] <= hot[r] ? REG_WRITE_N : ~REG_WRITE_N;
              end
              reg_d <= win_wdata;
            end else begin
              reg_ea <= hot;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          gnt      <= '0;
          reg_rw_n <= {NREG{~REG_WRITE_N}};
          reg_ea   <= '0;
          done     <= NREQ'(1) << idx_q;
          if (!we_q) begin
            // Nothing drives the bus for an unmapped address, so report zero.
            rdata <= (int'(addr_q) < NREG) ? reg_qa : '0;
          end
          state <= DONE;
        end
        DONE: begin
          done <= '0;
          busy <= 1'b0;
`ifndef REG_SCHED_FIXED_PRIO_EN
          ptr  <= (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
`endif
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_sched.sv
// tb_reg_access_sched
// Directed bench for reg_access_sched: a 4-register instance with a simple
// bank model, plus a 3-register instance for the unmapped-address case.
module tb_reg_access_sched;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [1:0]  req, req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy;
  logic [3:0]  reg_rw_n, reg_ea;
  logic [15:0] reg_d, reg_qa;

  logic [1:0]  req3, req_we3;
  logic [3:0]  req_addr3;
  logic [31:0] req_wdata3;
  logic [1:0]  gnt3, done3;
  logic [15:0] rdata3;
  logic        busy3;
  logic [2:0]  reg_rw_n3, reg_ea3;
  logic [15:0] reg_d3;
  logic [15:0] reg_qa3;

  logic [15:0] bank [4];

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  logic [1:0] expGnt;
  logic [3:0] expRwN;

  always #5 CLK = ~CLK;

  reg_access_sched dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .reg_rw_n  (reg_rw_n),
    .reg_ea    (reg_ea),
    .reg_d     (reg_d),
    .reg_qa    (reg_qa)
  );

  reg_access_sched #(.NREG(3)) dut3 (
    .CLK       (CLK),
    .CLR       (CLR),
    .req       (req3),
    .req_we    (req_we3),
    .req_addr  (req_addr3),
    .req_wdata (req_wdata3),
    .gnt       (gnt3),
    .done      (done3),
    .rdata     (rdata3),
    .busy      (busy3),
    .reg_rw_n  (reg_rw_n3),
    .reg_ea    (reg_ea3),
    .reg_d     (reg_d3),
    .reg_qa    (reg_qa3)
  );

  // The 3-register bus floats at a junk value, so only a correctly gated
  // capture can yield zero for the unmapped address.
  assign reg_qa3 = 16'hDEAD;

  // Bank model: active-low write strobes latch reg_d, read enables mux onto reg_qa.
  always @(posedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (!reg_rw_n[r]) bank[r] <= reg_d;
    end
  end

  always_comb begin
    reg_qa = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      if (reg_ea[r]) reg_qa = reg_qa | bank[r];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] we,
                               input logic [1:0] a0, input logic [1:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1);
    req       = r;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    CLR = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    req3 = 2'b00; req_we3 = 2'b00; req_addr3 = 4'h0; req_wdata3 = 32'h0;
    for (int i = 0; i < 4; i++) bank[i] = 16'h0000;
    tick();
    tick();
    checkOutput("reset_rw_n", reg_rw_n, 4'hF);
    checkOutput("reset_ea", reg_ea, 4'h0);
    checkOutput("reset_gnt", gnt, 2'b00);
    checkOutput("reset_done", done, 2'b00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rdata", rdata, 16'h0000);
    checkOutput("reset_reg_d", reg_d, 16'h0000);
    CLR = 1'b0;
    tick();

    $display("[TB] write 00AA to reg 2 by requester 0");
    applyStimulus(2'b01, 2'b01, 2'd2, 2'd0, 16'h00AA, 16'h0);
    tick();
    checkOutput("t1_rw_n", reg_rw_n, 4'b1011);
    checkOutput("t1_reg_d", reg_d, 16'h00AA);
    checkOutput("t1_gnt", gnt, 2'b01);
    checkOutput("t1_done_early", done, 2'b00);
    checkOutput("t1_busy", busy, 1'b1);
    checkOutput("t1_ea", reg_ea, 4'h0);
    tick();
    checkOutput("t1_done", done, 2'b01);
    checkOutput("t1_rw_n_off", reg_rw_n, 4'hF);
    checkOutput("t1_gnt_off", gnt, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    tick();
    checkOutput("t1_done_off", done, 2'b00);
    checkOutput("t1_busy_off", busy, 1'b0);
    checkOutput("t1_bank2", bank[2], 16'h00AA);

    $display("[TB] read reg 2 by requester 1");
    applyStimulus(2'b10, 2'b00, 2'd0, 2'd2, 16'h0, 16'h0);
    tick();
    checkOutput("t2_ea", reg_ea, 4'b0100);
    checkOutput("t2_gnt", gnt, 2'b10);
    checkOutput("t2_rw_n_acc", reg_rw_n, 4'hF);
    tick();
    checkOutput("t2_rdata", rdata, 16'h00AA);
    checkOutput("t2_done", done, 2'b10);
    checkOutput("t2_ea_off", reg_ea, 4'h0);
    checkOutput("t2_rw_n_done", reg_rw_n, 4'hF);
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    tick();

    $display("[TB] continuous contention");
    applyStimulus(2'b11, 2'b11, 2'd1, 2'd3, 16'h1234, 16'hBEEF);
    for (int t = 0; t < 4; t++) begin
`ifdef REG_SCHED_FIXED_PRIO_EN
      expGnt = 2'b01;
`else
      expGnt = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
      expRwN = (expGnt == 2'b01) ? 4'b1101 : 4'b0111;
      tick();
      checkOutput($sformatf("t3_gnt_%0d", t), gnt, expGnt);
      checkOutput($sformatf("t3_rw_n_%0d", t), reg_rw_n, expRwN);
      tick();
      checkOutput($sformatf("t3_done_%0d", t), done, expGnt);
      tick();
      checkOutput($sformatf("t3_idle_gnt_%0d", t), gnt, 2'b00);
    end
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    checkOutput("t3_bank1", bank[1], 16'h1234);
`ifndef REG_SCHED_FIXED_PRIO_EN
    checkOutput("t3_bank3", bank[3], 16'hBEEF);
`endif
    tick();

    $display("[TB] reset in the middle of an access");
    applyStimulus(2'b01, 2'b01, 2'd0, 2'd0, 16'h1111, 16'h0);
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    tick();
    applyStimulus(2'b10, 2'b10, 2'd0, 2'd0, 16'h0, 16'h5555);
    tick();
    checkOutput("t4_gnt_pre", gnt, 2'b10);
    checkOutput("t4_rw_n_pre", reg_rw_n, 4'b1110);
    #2;
    CLR = 1'b1;
    #1;
    checkOutput("t4_rw_n_async", reg_rw_n, 4'hF);
    checkOutput("t4_busy_async", busy, 1'b0);
    checkOutput("t4_gnt_async", gnt, 2'b00);
    tick();
    checkOutput("t4_no_done", done, 2'b00);
    checkOutput("t4_bank0", bank[0], 16'h1111);
    CLR = 1'b0;
    applyStimulus(2'b11, 2'b11, 2'd0, 2'd1, 16'h2222, 16'h3333);
    tick();
    checkOutput("t4_gnt_after", gnt, 2'b01);
    tick();
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    tick();

    $display("[TB] requester 0 drops req during access");
    applyStimulus(2'b01, 2'b00, 2'd1, 2'd0, 16'h0, 16'h0);
    tick();
    checkOutput("t5_gnt", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
    tick();
    checkOutput("t5_done", done, 2'b01);
    checkOutput("t5_rdata", rdata, 16'h1234);
    tick();
    checkOutput("t5_done_off", done, 2'b00);
    tick();
    checkOutput("t5_no_gnt", gnt, 2'b00);
    checkOutput("t5_no_busy", busy, 1'b0);
    checkOutput("t5_no_ea", reg_ea, 4'h0);

    $display("[TB] unmapped address with three registers");
    req3 = 2'b01; req_we3 = 2'b00; req_addr3 = 4'h1;
    tick();
    checkOutput("t6_ea_map", reg_ea3, 3'b010);
    tick();
    checkOutput("t6_rdata_map", rdata3, 16'hDEAD);
    req3 = 2'b00;
    tick();
    req3 = 2'b01; req_addr3 = 4'h3;
    tick();
    checkOutput("t6_ea_unmap", reg_ea3, 3'b000);
    checkOutput("t6_rw_n_unmap", reg_rw_n3, 3'b111);
    checkOutput("t6_gnt_unmap", gnt3, 2'b01);
    tick();
    checkOutput("t6_done_unmap", done3, 2'b01);
    checkOutput("t6_rdata_unmap", rdata3, 16'h0000);
    req3 = 2'b00;
    tick();
    checkOutput("t6_busy_off", busy3, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_access_sched.md
Name: reg_access_sched

Overview:
- Scheduler that shares a bank of sixteen-bit registers between NREQ requesters.
- Each register has an active-low write strobe and a read-enable onto a shared read bus.
- The block arbitrates round-robin, drives the per-register write strobe, read enable and write data, captures read data, and signals completion per requester.
- It sits between the ALU/load paths and the register bank.

Parameters:
- NREQ, 2, number of requesters
- NREG, 4, number of registers in the bank
- AW, 2, register address width
- W, 16, data width

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous reset, active-high
- req  in  NREQ  request per requester; held high until its done pulse
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  register address per requester (slice i = requester i)
- req_wdata  in  NREQ*W  write data per requester
- gnt  out  NREQ  one-hot grant, high during the access cycle
- done  out  NREQ  one-cycle completion pulse
- rdata  out  W  last read result; valid from the done cycle until the next read completes
- busy  out  1  high in any state except IDLE
- reg_rw_n  out  NREG  per-register write strobe, 0 = write
- reg_ea  out  NREG  per-register read enable, one-hot or zero
- reg_d  out  W  write data to the bank
- reg_qa  in  W  shared read bus from the bank

Behaviour:
- Reset (CLR=1, asynchronous):
  - state IDLE, round-robin pointer 0, rdata 0, reg_d 0
  - reg_rw_n all 1, reg_ea 0, gnt 0, done 0, busy 0
- All outputs come directly from flops; no combinational decode on the strobes.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner: the first requester at or after the pointer, scanning upward with wrap-around.
  - Latch idx, we, addr and wdata of the winner; next state ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt[idx]=1.
  - Write: reg_rw_n[addr]=0 and reg_d=wdata; the bank captures on the rising edge that ends this cycle.
  - Read: reg_ea[addr]=1; rdata<=reg_qa at the edge ending this cycle.
  - Next state DONE.
- DONE (1 cycle):
  - done[idx]=1, all strobes inactive.
  - Pointer <= (idx+1) mod NREQ; next state IDLE.
- Latency:
  - A req first seen in IDLE at edge k gives gnt in cycle k+1 and done in cycle k+2.
  - One transaction every 3 cycles under saturation.
- Simultaneous requests: the pointer decides; after reset requester 0 wins.
  - Under continuous contention the requesters alternate.
- req dropped after being latched: the transaction still completes and done still pulses.
- req_* inputs are ignored outside IDLE; the latched copy is used.
- Address >= NREG (only possible when NREG < 2**AW):
  - no strobe is asserted
  - a read returns rdata=0
  - done still pulses
- Reset during ACCESS:
  - Strobes deassert asynchronously.
  - The write is not guaranteed to land; no done is issued.
- Reads never drive reg_rw_n low. Writes never assert reg_ea.

Optional Feature:
- Macro REG_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is not implemented and DONE does not update it.
- Undefined: round-robin as described above.

Decomposition:
- Package reg_sched_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - default widths NREQ/NREG/AW/W
  - constant REG_WRITE_N = 1'b0
- Sub-module rr_pick:
  - combinational winner select from req and pointer; returns idx and a valid flag
  - holds the fixed-priority variant under the macro

Test Plan:
1. Reset then requester0 writes 16'h00AA to reg 2: reg_rw_n=4'b1011 for exactly 1 cycle with reg_d=16'h00AA; gnt=2'b01 the same cycle; done[0] pulses the next cycle.
2. Requester1 reads reg 2 with the bank model returning 16'h00AA: reg_ea=4'b0100 for 1 cycle; rdata=16'h00AA in the done cycle; reg_rw_n stays 4'hF throughout.
3. Both requesters continuously write (r0: reg1 16'h1234, r1: reg3 16'hBEEF): grants alternate 0,1,0,1, each with 3-cycle spacing; with REG_SCHED_FIXED_PRIO_EN, requester0 is granted every time.
4. CLR asserted mid-ACCESS of a write: reg_rw_n returns to 4'hF asynchronously; no done pulse; busy=0; the next request goes to requester 0.
5. Requester0 drops req in the ACCESS cycle: done[0] still pulses; no second transaction is started.
6. NREG=3 with a read of address 3: no reg_ea asserted; rdata=16'h0000; done pulses.
